// File: rtl/data_mem_access_unit_pkg.sv
// Shared load/store encodings, FSM states and the small decode helpers used by the MEM stage.
package data_mem_access_unit_pkg;

  localparam logic [1:0] MEM_ACC = 2'b01;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic legal_load(input logic [2:0] f3);
    legal_load = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic legal_store(input logic [2:0] f3);
    legal_store = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  // funct3[1:0] is the access size for both loads and stores: 00 byte, 01 half, 10 word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b01:   misaligned = lo[0];
      2'b10:   misaligned = (lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   byte_enables = 4'b0001 << lo;
      2'b01:   byte_enables = 4'b0011 << {lo[1], 1'b0};
      2'b10:   byte_enables = 4'b1111;
      default: byte_enables = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   replicate = {4{data[7:0]}};
      2'b01:   replicate = {2{data[15:0]}};
      default: replicate = data;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_access_unit_if.sv
// Data-memory req/ack bus: the access unit drives the master side, the memory the slave side.
interface data_mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/data_mem_access_unit_load_aligner.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it; purely combinational.
module load_aligner
  import data_mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[{addr_lo, 3'b000} +: 8];
    sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      F3_LW:   load_data = rdata;
      F3_LBU:  load_data = {24'd0, sel_byte};
      F3_LHU:  load_data = {16'd0, sel_half};
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store unit: IDLE->BUSY->DONE req/ack access, min latency 3 cycles (accept, ack, DONE).
// Stalls the pipeline while BUSY; faults (misaligned/illegal/timeout) pulse access_fault for one cycle.
module data_mem_access_unit
  import data_mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   mem_read,
  input  logic [1:0]                   mem_write,
  input  logic [2:0]                   funct3,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [31:0]                  store_data,
  output logic [31:0]                  load_data,
  output logic                         stall,
  output logic                         access_fault,
  data_mem_access_unit_if.master       mem
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        addr_lo_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       aligned;

  logic is_load;
  logic is_store;
  logic any_acc;
  logic bad_acc;
  logic accept;
  logic fault_idle;
  logic timeout;

  always_comb begin
    is_load  = (mem_read == MEM_ACC);
    is_store = (mem_write == MEM_ACC);
    any_acc  = is_load || is_store;
    bad_acc  = any_acc && ((is_load && is_store) ||
                           (is_load && !legal_load(funct3)) ||
                           (is_store && !legal_store(funct3)) ||
                           misaligned(funct3[1:0], addr[1:0]));
    accept     = (state == IDLE) && any_acc && !bad_acc;
    fault_idle = (state == IDLE) && bad_acc;
    // Final BUSY cycle is the TIMEOUT_CYCLES-th one; an ack in that same cycle still wins.
    timeout    = (state == BUSY) && !mem.mem_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (mem.mem_ack || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall is gated by rst_n so a held instruction cannot keep the pipeline frozen during reset.
  always_comb begin
    stall       = rst_n && (accept || (state == BUSY));
    mem.mem_req = (state == BUSY);
  end

  load_aligner u_load_aligner (
    .rdata     (mem.mem_rdata),
    .addr_lo   (addr_lo_q),
    .funct3    (f3_q),
    .load_data (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      addr_q       <= '0;
      addr_lo_q    <= '0;
      f3_q         <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      load_data    <= '0;
      access_fault <= 1'b0;
    end else begin
      access_fault <= fault_idle || timeout;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt       <= '0;
            addr_q    <= {addr[ADDR_W-1:2], 2'b00};
            addr_lo_q <= addr[1:0];
            f3_q      <= funct3;
            we_q      <= is_store;
            be_q      <= byte_enables(funct3[1:0], addr[1:0]);
            wdata_q   <= is_store ? replicate(funct3[1:0], store_data) : 32'd0;
          end else if (fault_idle) begin
            load_data <= '0;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (mem.mem_ack) begin
            load_data <= we_q ? 32'd0 : aligned;
          end else if (timeout) begin
            load_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for the MEM-stage access unit; inputs change on the falling edge, checks 1ns later.
module tb_data_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mem_read;
  logic [1:0]  mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        stall;
  logic        access_fault;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_access_unit_if #(.ADDR_W(32)) bus ();

  data_mem_access_unit #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .load_data    (load_data),
    .stall        (stall),
    .access_fault (access_fault),
    .mem          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_op(input logic [1:0] rd, input logic [1:0] wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd);
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = sd;
  endtask

  task automatic clear_op();
    drive_op(2'b00, 2'b00, 3'b000, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_op();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({bus.mem_req, bus.mem_we, stall, access_fault} !== 4'b0000) begin n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {bus.mem_req, bus.mem_we, stall, access_fault}); end
    n_cmp++; if (bus.mem_addr !== 32'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr); end
    n_cmp++; if ({bus.mem_be, bus.mem_wdata} !== 36'd0) begin n_bad++; $display("FAIL reset_be_wdata: got %h want 0", {bus.mem_be, bus.mem_wdata}); end
    n_cmp++; if (load_data !== 32'd0) begin n_bad++; $display("FAIL reset_load_data: got %h want 0", load_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lb();
    @(negedge clk);
    drive_op(2'b01, 2'b00, 3'b000, 32'h0000_1003, 32'd0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lb_accept_stall: got %b want 1", stall); end
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL lb_accept_req: got %b want 0", bus.mem_req); end
    @(negedge clk); #1;
    n_cmp++; if ({bus.mem_req, bus.mem_we, stall} !== 3'b101) begin n_bad++; $display("FAIL lb_busy1_ctrl: got %b want 101", {bus.mem_req, bus.mem_we, stall}); end
    n_cmp++; if (bus.mem_addr !== 32'h0000_1000) begin n_bad++; $display("FAIL lb_addr: got %h want 00001000", bus.mem_addr); end
    n_cmp++; if (bus.mem_be !== 4'b1000) begin n_bad++; $display("FAIL lb_be: got %b want 1000", bus.mem_be); end
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h80AA_BBCC;
    #1;
    n_cmp++; if ({bus.mem_req, stall} !== 2'b11) begin n_bad++; $display("FAIL lb_busy2_ctrl: got %b want 11", {bus.mem_req, stall}); end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    clear_op();
    #1;
    n_cmp++; if ({bus.mem_req, stall} !== 2'b00) begin n_bad++; $display("FAIL lb_done_ctrl: got %b want 00", {bus.mem_req, stall}); end
    n_cmp++; if (load_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_load_data: got %h want ffffff80", load_data); end
    @(negedge clk); #1;
    n_cmp++; if ({bus.mem_req, stall, access_fault} !== 3'b000) begin n_bad++; $display("FAIL lb_idle_after: got %b want 000", {bus.mem_req, stall, access_fault}); end
  endtask

  task automatic test_faults();
    logic [1:0]  rd_t [6] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    logic [1:0]  wr_t [6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01};
    logic [2:0]  f3_t [6] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b010};
    logic [31:0] a_t  [6] = '{32'h4001, 32'h4003, 32'h4002, 32'h4000, 32'h4000, 32'h4000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_op(rd_t[i], wr_t[i], f3_t[i], a_t[i], 32'h1111_2222);
      #1;
      n_cmp++; if ({bus.mem_req, stall, access_fault} !== 3'b000) begin n_bad++; $display("FAIL fault%0d_issue: got %b want 000", i, {bus.mem_req, stall, access_fault}); end
      @(negedge clk);
      clear_op();
      #1;
      n_cmp++; if ({bus.mem_req, stall, access_fault} !== 3'b001) begin n_bad++; $display("FAIL fault%0d_pulse: got %b want 001", i, {bus.mem_req, stall, access_fault}); end
      n_cmp++; if (load_data !== 32'd0) begin n_bad++; $display("FAIL fault%0d_load_data: got %h want 0", i, load_data); end
      @(negedge clk); #1;
      n_cmp++; if (access_fault !== 1'b0) begin n_bad++; $display("FAIL fault%0d_one_cycle: got %b want 0", i, access_fault); end
    end
  endtask

  task automatic test_lhu();
    @(negedge clk);
    drive_op(2'b01, 2'b00, 3'b101, 32'h0000_2002, 32'd0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lhu_accept_stall: got %b want 1", stall); end
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h8001_1234;
    #1;
    n_cmp++; if ({bus.mem_req, stall} !== 2'b11) begin n_bad++; $display("FAIL lhu_busy_ctrl: got %b want 11", {bus.mem_req, stall}); end
    n_cmp++; if (bus.mem_be !== 4'b1100) begin n_bad++; $display("FAIL lhu_be: got %b want 1100", bus.mem_be); end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    clear_op();
    #1;
    n_cmp++; if ({bus.mem_req, stall} !== 2'b00) begin n_bad++; $display("FAIL lhu_done_ctrl: got %b want 00", {bus.mem_req, stall}); end
    n_cmp++; if (load_data !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu_load_data: got %h want 00008001", load_data); end
    @(negedge clk);
  endtask

  task automatic test_sh();
    @(negedge clk);
    drive_op(2'b00, 2'b01, 3'b001, 32'h0000_3002, 32'hDEAD_BEEF);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sh_accept_stall: got %b want 1", stall); end
    @(negedge clk); #1;
    n_cmp++; if ({bus.mem_req, bus.mem_we} !== 2'b11) begin n_bad++; $display("FAIL sh_req_we: got %b want 11", {bus.mem_req, bus.mem_we}); end
    n_cmp++; if (bus.mem_be !== 4'b1100) begin n_bad++; $display("FAIL sh_be: got %b want 1100", bus.mem_be); end
    n_cmp++; if (bus.mem_wdata !== 32'hBEEF_BEEF) begin n_bad++; $display("FAIL sh_wdata: got %h want beefbeef", bus.mem_wdata); end
    n_cmp++; if (bus.mem_addr !== 32'h0000_3000) begin n_bad++; $display("FAIL sh_addr: got %h want 00003000", bus.mem_addr); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    clear_op();
    #1;
    n_cmp++; if (load_data !== 32'd0) begin n_bad++; $display("FAIL sh_load_data: got %h want 0", load_data); end
    n_cmp++; if ({bus.mem_req, stall} !== 2'b00) begin n_bad++; $display("FAIL sh_done_ctrl: got %b want 00", {bus.mem_req, stall}); end
    @(negedge clk);
  endtask

  task automatic test_lw_ok();
    @(negedge clk);
    drive_op(2'b01, 2'b00, 3'b010, 32'h0000_6000, 32'd0);
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    #1;
    n_cmp++; if (bus.mem_be !== 4'b1111) begin n_bad++; $display("FAIL lw_be: got %b want 1111", bus.mem_be); end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    clear_op();
    #1;
    n_cmp++; if (load_data !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL lw_load_data: got %h want cafef00d", load_data); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int busy_seen = 0;
    @(negedge clk);
    drive_op(2'b00, 2'b01, 3'b010, 32'h0000_5000, 32'h1234_5678);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      clear_op();
      #1;
      if (i == 0) begin
        n_cmp++; if ({bus.mem_we, bus.mem_be, bus.mem_wdata} !== {1'b1, 4'b1111, 32'h1234_5678}) begin n_bad++; $display("FAIL sw_bus_fields: got %h want 1f12345678", {bus.mem_we, bus.mem_be, bus.mem_wdata}); end
      end
      if (bus.mem_req && stall && !access_fault) busy_seen++;
    end
    n_cmp++; if (busy_seen !== 16) begin n_bad++; $display("FAIL to_busy_cycles: got %0d want 16", busy_seen); end
    @(negedge clk); #1;
    n_cmp++; if ({bus.mem_req, stall, access_fault} !== 3'b001) begin n_bad++; $display("FAIL to_done: got %b want 001", {bus.mem_req, stall, access_fault}); end
    n_cmp++; if (load_data !== 32'd0) begin n_bad++; $display("FAIL to_load_data: got %h want 0", load_data); end
    @(negedge clk); #1;
    n_cmp++; if ({bus.mem_req, stall, access_fault} !== 3'b000) begin n_bad++; $display("FAIL to_idle: got %b want 000", {bus.mem_req, stall, access_fault}); end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    drive_op(2'b01, 2'b00, 3'b010, 32'h0000_7000, 32'd0);
    @(negedge clk); #1;
    n_cmp++; if (bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy_req: got %b want 1", bus.mem_req); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.mem_req, stall} !== 2'b00) begin n_bad++; $display("FAIL rst_mid_drop: got %b want 00", {bus.mem_req, stall}); end
    @(negedge clk);
    clear_op();
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if ({bus.mem_req, stall} !== 2'b00) begin n_bad++; $display("FAIL late_ack_ctrl: got %b want 00", {bus.mem_req, stall}); end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    n_cmp++; if (load_data !== 32'd0) begin n_bad++; $display("FAIL late_ack_load_data: got %h want 0", load_data); end
    drive_op(2'b01, 2'b00, 3'b010, 32'h0000_7004, 32'd0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL post_rst_accept: got %b want 1", stall); end
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    #1;
    n_cmp++; if (bus.mem_addr !== 32'h0000_7004) begin n_bad++; $display("FAIL post_rst_addr: got %h want 00007004", bus.mem_addr); end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    clear_op();
    #1;
    n_cmp++; if (load_data !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL post_rst_load_data: got %h want 0badf00d", load_data); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL post_rst_done_stall: got %b want 0", stall); end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_faults();
    test_lhu();
    test_sh();
    test_lw_ok();
    test_timeout();
    test_reset_mid_busy();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- MEM-stage block that consumes the decoder's mem_read/mem_write/funct3 controls plus the EX result address and rs2 store data.
- Runs a req/ack handshake to data memory with word-aligned address, byte enables and lane-replicated write data.
- Stalls the pipeline while an access is outstanding and returns aligned, sign- or zero-extended load data.
- Flags misaligned, illegal-width and timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in BUSY without mem_ack before the access is aborted with a fault.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read  in  2  2'b01 = load; any other value = no load.
- mem_write  in  2  2'b01 = store; any other value = no store.
- funct3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  ADDR_W  byte address from ALU.
- store_data  in  32  rs2 value.
- load_data  out  32  extended load result; valid in DONE.
- stall  out  1  holds the IF..MEM pipeline registers.
- access_fault  out  1  one-cycle pulse on a misaligned, illegal or timed-out access.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  addr with bits [1:0] forced to 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word.
- mem_ack  in  1  one-cycle completion strobe.

Behaviour:
- Reset (asynchronous, takes effect immediately even mid-access):
  - state = IDLE.
  - mem_req, mem_we, stall, access_fault = 0; mem_addr, mem_be, mem_wdata, load_data = 0; timeout counter = 0.
- States: IDLE, BUSY, DONE.
- IDLE, valid access present (exactly one of mem_read/mem_write == 01, legal funct3, aligned):
  - stall = 1 combinationally in the same cycle.
  - Latch addr, funct3, we, be and wdata.
  - Next state BUSY; mem_req = 1 from the next cycle.
- IDLE, faulting access:
  - Faults: misaligned (H/HU/SH with addr[0] = 1; W/SW with addr[1:0] != 0), illegal funct3 (load 011/110/111; store > 010), or both mem_read and mem_write == 01.
  - No bus activity; stall = 0; access_fault pulses 1 in the next cycle; load_data = 0.
- IDLE, no access: outputs hold idle values.
- BUSY:
  - mem_req = 1; latched bus fields stable; stall = 1; counter increments each cycle.
  - On mem_ack: load_data <= extracted/extended rdata (loads) or 0 (stores); mem_req drops next cycle; next state DONE.
  - Counter reaching TIMEOUT_CYCLES with no ack: mem_req drops, access_fault pulses, load_data = 0, next state DONE.
  - mem_ack while in IDLE or DONE is ignored.
- DONE:
  - stall = 0, so the pipeline advances exactly once; load_data is held valid.
  - Inputs are ignored, so the same instruction cannot be retriggered.
  - Next state is always IDLE.
- Minimum load/store latency: 3 cycles (accept, BUSY with ack, DONE). Back-to-back accesses re-enter BUSY from IDLE the cycle after DONE.
- Byte enables and write data:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{store_data[7:0]}}.
  - SH: be = 4'b0011 << {addr[1],1'b0}; wdata = {2{store_data[15:0]}}.
  - SW: be = 4'b1111; wdata = store_data.
  - Loads: mem_we = 0; be = the same pattern by width.
- Load extraction: select byte/half by the latched addr[1:0]; B/H sign-extend; BU/HU zero-extend; W passes the word through.

Decomposition:
- Shared constants file encordings.v, extended with:
  - MEM_ACC = 2'b01.
  - Load/store funct3 codes: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - State encodings: IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10.
- One combinational sub-module, load_aligner (rdata, addr_lo[1:0], funct3 -> load_data), reused by the verification model.
- Byte-enable and replication logic stays inline.

Test Plan:
- LB, addr 0x1003, mem_rdata 0x80AABBCC, ack in the 2nd BUSY cycle -> mem_addr 0x1000, be 1000, load_data 0xFFFFFF80, stall high for 3 cycles then low for exactly 1 DONE cycle.
- LHU, addr 0x2002, rdata 0x8001_1234, immediate ack -> be 1100, load_data 0x00008001; total latency 3 cycles.
- SH, addr 0x3002, store_data 0xDEADBEEF -> mem_we 1, be 1100, mem_wdata 0xBEEFBEEF, mem_addr 0x3000; load_data 0.
- LW, addr 0x4001 -> no mem_req, stall never asserts, access_fault one-cycle pulse.
- SW with mem_ack withheld -> after 16 BUSY cycles mem_req drops, access_fault pulses, DONE, then IDLE.
- rst_n low mid-BUSY -> mem_req and stall drop immediately; a late mem_ack after release is ignored; the next LW completes normally.
